ntt_sequencer: RTL and testbench

- Address and stage sequencer for the NTT butterfly datapath.
- Walks all logN stages and issues N/2 butterfly operations per stage as (lo index, hi index, twiddle index) over a valid/ready handshake.
- Tracks butterflies in flight and drains the datapath pipeline between stages, so stage s+1 never reads a coefficient before stage s has written it back.
- Sits between the top-level polynomial controller (start/done) and the coefficient-RAM/butterfly pipeline.

---
 rtl/ntt_pkg.sv | 17 +
 rtl/ntt_bf_index.sv | 38 +++
 rtl/ntt_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ntt_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: constants and FSM encoding shared by the NTT sequencer,
// the butterfly datapath and the twiddle ROM.
package ntt_pkg;

  localparam int NTT_N       = 1024;
  localparam int NTT_LOGN    = $clog2(NTT_N);
  localparam int NTT_TW_W    = NTT_LOGN - 1;
  localparam int NTT_MAX_OUT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ntt_bf_index.sv
// ntt_bf_index: combinational (stage, j) -> (lo, hi, tw) butterfly index map.
// Ports: i_stage, i_j in; o_lo, o_hi (LOGN bits), o_tw (LOGN-1 bits) out.
module ntt_bf_index
  import ntt_pkg::*;
#(
  parameter int LOGN = NTT_LOGN
) (
  input  logic [LOGN-1:0] i_stage,
  input  logic [LOGN-2:0] i_j,
  output logic [LOGN-1:0] o_lo,
  output logic [LOGN-1:0] o_hi,
  output logic [LOGN-2:0] o_tw
);

  localparam logic [LOGN-2:0] ONE_S  = (LOGN-1)'(1);
  localparam logic [LOGN-1:0] ONE    = LOGN'(1);
  localparam logic [LOGN-1:0] SH_TOP = LOGN'(LOGN-1);

  logic [LOGN-2:0] w_mask;
  logic [LOGN-2:0] w_jm;
  logic [LOGN-1:0] w_jx;
  logic [LOGN-1:0] w_lo;

  // At the last stage 1<<stage wraps to 0 in LOGN-1 bits,
  // so the subtraction yields the all-ones mask it needs.
  always_comb begin
    w_mask = (ONE_S << i_stage) - ONE_S;
    w_jm   = i_j & w_mask;
    w_jx   = {1'b0, i_j};
    w_lo   = (((w_jx >> i_stage) << i_stage) << 1)
           | {1'b0, w_jm};
  end

  assign o_lo = w_lo;
  assign o_hi = w_lo | (ONE << i_stage);
  assign o_tw = w_jm << (SH_TOP - i_stage);

endmodule

// File: rtl/ntt_sequencer.sv
// ntt_sequencer: walks all NTT stages, issues N/2 butterflies per stage
// over bf_valid/bf_ready, drains in-flight write-backs between stages.
// Ports: clk, reset (async, active-low), start -> busy, done;
//   bf_valid/bf_ready, bf_addr_lo/hi, bf_tw_idx, bf_stage; wb_valid.
// Optional NTT_SEQ_INVERSE_EN: inverse in, bf_inverse out; stages run
//   LOGN-1 down to 0 when inverse is sampled high with start.
module ntt_sequencer
  import ntt_pkg::*;
#(
  parameter int N       = NTT_N,
  parameter int LOGN    = $clog2(N),
  parameter int MAX_OUT = NTT_MAX_OUT,
  parameter int OUTW    = $clog2(MAX_OUT+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef NTT_SEQ_INVERSE_EN
  input  logic            inverse,
  output logic            bf_inverse,
`endif
  output logic            busy,
  output logic            done,
  output logic            bf_valid,
  input  logic            bf_ready,
  output logic [LOGN-1:0] bf_addr_lo,
  output logic [LOGN-1:0] bf_addr_hi,
  output logic [LOGN-2:0] bf_tw_idx,
  output logic [LOGN-1:0] bf_stage,
  input  logic            wb_valid
);

  localparam int              HALF    = N / 2;
  localparam logic [LOGN-1:0] ST_LAST = LOGN'(LOGN-1);
  localparam logic [LOGN-2:0] J_LAST  = (LOGN-1)'(HALF-1);
  localparam logic [OUTW-1:0] OUT_MAX = OUTW'(MAX_OUT);
  localparam logic [OUTW-1:0] OUT_ONE = OUTW'(1);

  seq_state_t      r_state;
  seq_state_t      w_state_nx;
  logic [LOGN-1:0] r_stage;
  logic [LOGN-1:0] w_stage_nx;
  logic [LOGN-2:0] r_j;
  logic [LOGN-2:0] w_j_nx;
  logic [OUTW-1:0] r_out;
  logic [OUTW-1:0] w_out_nx;

  logic            w_act;
  logic            w_hs;
  logic            w_dec;
  logic            w_last_j;
  logic            w_last_st;
  logic [LOGN-1:0] w_lo;
  logic [LOGN-1:0] w_hi;
  logic [LOGN-2:0] w_tw;

`ifdef NTT_SEQ_INVERSE_EN
  logic            r_inv;
  logic            w_inv_nx;
`endif

  ntt_bf_index #(
    .LOGN (LOGN)
  ) u_idx (
    .i_stage (r_stage),
    .i_j     (r_j),
    .o_lo    (w_lo),
    .o_hi    (w_hi),
    .o_tw    (w_tw)
  );

  assign w_act    = (r_state != IDLE);
  assign bf_valid = (r_state == ISSUE)
                  && (r_out < OUT_MAX);
  assign w_hs     = bf_valid && bf_ready;
  // A write-back with nothing in flight is dropped,
  // keeping the counter pinned at zero.
  assign w_dec    = wb_valid && (r_out != '0);
  assign w_last_j = (r_j == J_LAST);

`ifdef NTT_SEQ_INVERSE_EN
  assign w_last_st  = r_inv ? (r_stage == '0)
                            : (r_stage == ST_LAST);
  assign bf_inverse = w_act && r_inv;
`else
  assign w_last_st  = (r_stage == ST_LAST);
`endif

  assign busy       = w_act;
  assign done       = (r_state == FINISH);
  assign bf_addr_lo = w_act ? w_lo : '0;
  assign bf_addr_hi = w_act ? w_hi : '0;
  assign bf_tw_idx  = w_act ? w_tw : '0;
  assign bf_stage   = w_act ? r_stage : '0;

  always_comb begin
    w_out_nx = r_out;
    unique case ({w_hs, w_dec})
      2'b10:   w_out_nx = r_out + OUT_ONE;
      2'b01:   w_out_nx = r_out - OUT_ONE;
      default: w_out_nx = r_out;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_stage_nx = r_stage;
    w_j_nx     = r_j;
`ifdef NTT_SEQ_INVERSE_EN
    w_inv_nx   = r_inv;
`endif
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nx = ISSUE;
          w_j_nx     = '0;
`ifdef NTT_SEQ_INVERSE_EN
          w_inv_nx   = inverse;
          w_stage_nx = inverse ? ST_LAST : '0;
`else
          w_stage_nx = '0;
`endif
        end
      end
      ISSUE: begin
        if (w_hs) begin
          if (w_last_j) begin
            w_j_nx     = '0;
            w_state_nx = DRAIN;
          end else begin
            w_j_nx = r_j + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Next stage may only start once every
        // write-back of this stage has retired.
        if (r_out == '0) begin
          if (w_last_st) begin
            w_state_nx = FINISH;
          end else begin
            w_state_nx = ISSUE;
`ifdef NTT_SEQ_INVERSE_EN
            w_stage_nx = r_inv ? r_stage - 1'b1
                               : r_stage + 1'b1;
`else
            w_stage_nx = r_stage + 1'b1;
`endif
          end
        end
      end
      FINISH: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_j     <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_stage <= w_stage_nx;
      r_j     <= w_j_nx;
      r_out   <= w_out_nx;
    end
  end

`ifdef NTT_SEQ_INVERSE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inv <= 1'b0;
    end else begin
      r_inv <= w_inv_nx;
    end
  end
`endif

`ifndef SYNTHESIS
  a_wb_underflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(wb_valid && (r_out == '0))
  );
`endif

endmodule

// File: tb/tb_ntt_sequencer.sv
// tb_ntt_sequencer: table vectors, hand sequences and randomized runs
// against an arithmetic butterfly-order model for ntt_sequencer.
module tb_ntt_sequencer;

  localparam int N    = 8;
  localparam int LOGN = 3;
  localparam int MAXO = 4;

  typedef struct {
    int st;
    int lo;
    int hi;
    int tw;
  } bf_t;

  typedef struct {
    int  stall;
    bf_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic            bf_ready = 1'b0;
  logic            wb_valid = 1'b0;
  logic            busy, done, bf_valid;
  logic [LOGN-1:0] bf_addr_lo, bf_addr_hi, bf_stage;
  logic [LOGN-2:0] bf_tw_idx;
`ifdef NTT_SEQ_INVERSE_EN
  logic            inverse = 1'b0;
  logic            bf_inverse;
  logic            bf_inverse16;
`endif

  logic       start16 = 1'b0;
  logic       ready16 = 1'b0;
  logic       wb16 = 1'b0;
  logic       busy16, done16, valid16;
  logic [3:0] lo16, hi16, stage16;
  logic [2:0] tw16;

  ntt_sequencer #(.N(N), .MAX_OUT(MAXO)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef NTT_SEQ_INVERSE_EN
    .inverse    (inverse),
    .bf_inverse (bf_inverse),
`endif
    .busy       (busy),
    .done       (done),
    .bf_valid   (bf_valid),
    .bf_ready   (bf_ready),
    .bf_addr_lo (bf_addr_lo),
    .bf_addr_hi (bf_addr_hi),
    .bf_tw_idx  (bf_tw_idx),
    .bf_stage   (bf_stage),
    .wb_valid   (wb_valid)
  );

  ntt_sequencer #(.N(16), .MAX_OUT(MAXO)) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .start      (start16),
`ifdef NTT_SEQ_INVERSE_EN
    .inverse    (1'b0),
    .bf_inverse (bf_inverse16),
`endif
    .busy       (busy16),
    .done       (done16),
    .bf_valid   (valid16),
    .bf_ready   (ready16),
    .bf_addr_lo (lo16),
    .bf_addr_hi (hi16),
    .bf_tw_idx  (tw16),
    .bf_stage   (stage16),
    .wb_valid   (wb16)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[12];
  bf_t  expq[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected issue order straight from the index rules.
  task automatic load_model(input bit inv);
    bf_t e;
    int  s, p;
    expq.delete();
    for (int k = 0; k < LOGN; k++) begin
      s = inv ? (LOGN - 1 - k) : k;
      p = 1 << s;
      for (int j = 0; j < N / 2; j++) begin
        e.st = s;
        e.lo = (j / p) * 2 * p + (j % p);
        e.hi = e.lo + p;
        e.tw = (j % p) * (1 << (LOGN - 1 - s));
        expq.push_back(e);
      end
    end
  endtask

  task automatic load_table();
    expq.delete();
    foreach (tbl[i]) expq.push_back(tbl[i].e);
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_valid"}, int'(bf_valid), 0);
    chk({tag, "_lo"}, int'(bf_addr_lo), 0);
    chk({tag, "_hi"}, int'(bf_addr_hi), 0);
    chk({tag, "_tw"}, int'(bf_tw_idx), 0);
    chk({tag, "_stage"}, int'(bf_stage), 0);
  endtask

  // One transform on the N=8 instance. Write-backs come back in order,
  // each dmin..dmax cycles after its handshake.
  task automatic run_xfer(input bit inv, input bit use_tbl,
                          input int rdy_pct, input int dmin,
                          input int dmax, input int abort_st,
                          input bit chk_lat);
    bit  sched[1024];
    int  cyc, mout, last_due, dcnt, done_cyc;
    int  tidx, stall_left, d, due;
    int  p_lo, p_hi, p_tw, p_st;
    bit  prev_stall, rdy, hs, fin, aborted;
    bf_t e;
    foreach (sched[i]) sched[i] = 1'b0;
    cyc = 0; mout = 0; last_due = 0; dcnt = 0; done_cyc = -1;
    tidx = 0; stall_left = use_tbl ? tbl[0].stall : 0;
    prev_stall = 0; fin = 0; aborted = 0;
    p_lo = 0; p_hi = 0; p_tw = 0; p_st = 0;
`ifdef NTT_SEQ_INVERSE_EN
    inverse = inv;
`endif
    start = 1'b1; bf_ready = 1'b0; wb_valid = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    chk("first_valid", int'(bf_valid), 1);
    chk("busy_on", int'(busy), 1);
    while (!fin && cyc < 1000) begin
      if (done) begin
        dcnt++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("busy_in_done", int'(busy), 1);
      end else if (done_cyc >= 0) begin
        chk("busy_after_done", int'(busy), 0);
        fin = 1;
      end
      if (!fin) begin
        if (mout >= MAXO) chk("throttle", int'(bf_valid), 0);
        if (prev_stall) begin
          chk("hold_valid", int'(bf_valid), 1);
          chk("hold_lo", int'(bf_addr_lo), p_lo);
          chk("hold_hi", int'(bf_addr_hi), p_hi);
          chk("hold_tw", int'(bf_tw_idx), p_tw);
          chk("hold_stage", int'(bf_stage), p_st);
        end
        wb_valid = sched[cyc];
        if (wb_valid) mout--;
        if (use_tbl) begin
          rdy = !(bf_valid && stall_left > 0);
          if (bf_valid && stall_left > 0) stall_left--;
        end else begin
          rdy = int'($urandom_range(99)) < rdy_pct;
        end
        bf_ready = rdy;
        hs = bf_valid && rdy;
        if (hs && abort_st >= 0 && int'(bf_stage) == abort_st) begin
          reset = 1'b0;
          #1;
          chk_idle8("abort");
          bf_ready = 1'b0;
          wb_valid = 1'b0;
          step();
          step();
          reset = 1'b1;
          for (int k = 0; k < 3; k++) begin
            chk("abort_no_done", int'(done), 0);
            chk("abort_no_busy", int'(busy), 0);
            step();
          end
          aborted = 1;
          fin = 1;
        end else begin
          if (hs) begin
            if (expq.size() == 0) begin
              chk("extra_issue", 1, 0);
            end else begin
              e = expq.pop_front();
              chk("stage", int'(bf_stage), e.st);
              chk("lo", int'(bf_addr_lo), e.lo);
              chk("hi", int'(bf_addr_hi), e.hi);
              chk("tw", int'(bf_tw_idx), e.tw);
`ifdef NTT_SEQ_INVERSE_EN
              chk("bf_inverse", int'(bf_inverse), int'(inv));
`endif
            end
            d = int'($urandom_range(dmax, dmin));
            due = cyc + d;
            if (due <= last_due) due = last_due + 1;
            if (due < 1024) sched[due] = 1'b1;
            last_due = due;
            mout++;
            if (use_tbl) begin
              tidx++;
              if (tidx < 12) stall_left = tbl[tidx].stall;
            end
          end
          prev_stall = bf_valid && !rdy;
          p_lo = int'(bf_addr_lo);
          p_hi = int'(bf_addr_hi);
          p_tw = int'(bf_tw_idx);
          p_st = int'(bf_stage);
          step();
          cyc++;
        end
      end
    end
    bf_ready = 1'b0;
    wb_valid = 1'b0;
    if (!aborted) begin
      chk("finished_in_time", int'(fin), 1);
      chk("done_pulses", dcnt, 1);
      chk("all_issued", expq.size(), 0);
      if (chk_lat)
        chk("latency", done_cyc + 1, LOGN * (N / 2 + dmin + 1) + 2);
    end
  endtask

  // N=16 instance: in-flight limit and simultaneous issue/retire.
  task automatic throttle_seq();
    int n;
    start16 = 1'b1; ready16 = 1'b0; wb16 = 1'b0;
    step();
    start16 = 1'b0;
    ready16 = 1'b1;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (valid16) n++;
      wb16 = (k == 2);
      step();
    end
    wb16 = 1'b0;
    chk("t_first3", n, 3);
    n = 0;
    repeat (6) begin
      if (valid16) n++;
      step();
    end
    chk("t_fill_to_max", n, 2);
    chk("t_withheld", int'(valid16), 0);
    wb16 = 1'b1;
    step();
    wb16 = 1'b0;
    n = 0;
    repeat (5) begin
      if (valid16) n++;
      step();
    end
    chk("t_one_more", n, 1);
    chk("t_withheld2", int'(valid16), 0);
    chk("t_busy", int'(busy16), 1);
    chk("t_stage0", int'(stage16), 0);
    ready16 = 1'b0;
    reset = 1'b0;
    #1;
    chk("t_abort_busy", int'(busy16), 0);
    chk("t_abort_hi", int'(hi16), 0);
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    tbl[0]  = '{0, '{0, 0, 1, 0}};
    tbl[1]  = '{2, '{0, 2, 3, 0}};
    tbl[2]  = '{0, '{0, 4, 5, 0}};
    tbl[3]  = '{1, '{0, 6, 7, 0}};
    tbl[4]  = '{3, '{1, 0, 2, 0}};
    tbl[5]  = '{0, '{1, 1, 3, 2}};
    tbl[6]  = '{0, '{1, 4, 6, 0}};
    tbl[7]  = '{1, '{1, 5, 7, 2}};
    tbl[8]  = '{0, '{2, 0, 4, 0}};
    tbl[9]  = '{0, '{2, 1, 5, 1}};
    tbl[10] = '{2, '{2, 2, 6, 2}};
    tbl[11] = '{0, '{2, 3, 7, 3}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle8("reset");
    chk("reset16_valid", int'(valid16), 0);
    chk("reset16_hi", int'(hi16), 0);
    reset = 1'b1;
    step();
    chk_idle8("idle");

    load_table();
    run_xfer(1'b0, 1'b1, 0, 2, 2, -1, 1'b0);
    step();

    load_model(1'b0);
    run_xfer(1'b0, 1'b0, 100, 2, 2, -1, 1'b1);
    step();

    throttle_seq();

    for (int r = 0; r < 4; r++) begin
      load_model(1'b0);
      run_xfer(1'b0, 1'b0, 60, 1, 5, -1, 1'b0);
      step();
    end

    load_model(1'b0);
    run_xfer(1'b0, 1'b0, 100, 2, 2, 1, 1'b0);
    load_model(1'b0);
    run_xfer(1'b0, 1'b0, 100, 2, 2, -1, 1'b1);
    step();

`ifdef NTT_SEQ_INVERSE_EN
    load_model(1'b1);
    run_xfer(1'b1, 1'b0, 70, 1, 4, -1, 1'b0);
    step();
    load_table();
    run_xfer(1'b0, 1'b1, 0, 2, 2, -1, 1'b0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
